// File: rtl/tw_rom_param.sv
// Run-time writable twiddle buffer: NUM_STAGES x GROUPS x DEPTH words plus one constant per stage,
// read through an internal idx/rep/grp sequencer. Optional macro: TW_ROM_PARAM_WR_ERR_EN (sticky wr_err).
module tw_rom_param #(
    parameter int P_WIDTH    = 64,
    parameter int SC_WIDTH   = 3,
    parameter int NUM_STAGES = 3,
    parameter int DEPTH      = 4,
    parameter int GROUPS     = 4,
    parameter int REPEAT     = 16,
    parameter logic [P_WIDTH-1:0] CONST_INIT = 64'hfff7ffff00000001,
    parameter int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                CEN,
    input  logic                advance,
    input  logic [SC_WIDTH-1:0] stage_counter,
    input  logic                wr_en,
    input  logic                cw_en,
    input  logic [SC_WIDTH-1:0] wr_stage,
    input  logic [GW-1:0]       wr_group,
    input  logic [IW-1:0]       wr_addr,
    input  logic [P_WIDTH-1:0]  wr_data,
    output logic [P_WIDTH-1:0]  Q,
    output logic [P_WIDTH-1:0]  Q_const,
    output logic [GW-1:0]       group_th,
    output logic                sweep_done,
    output logic                wr_err
);

    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [P_WIDTH-1:0] ONE = P_WIDTH'(1);

    logic [P_WIDTH-1:0]  mem_q   [NUM_STAGES][GROUPS][DEPTH];
    logic [P_WIDTH-1:0]  const_q [NUM_STAGES];
    logic [P_WIDTH-1:0]  q_q, qc_q;
    logic [IW-1:0]       idx_q, idx_d, rd_idx;
    logic [RW-1:0]       rep_q, rep_d, rd_rep;
    logic [GW-1:0]       grp_q, grp_d, rd_grp;
    logic [SC_WIDTH-1:0] prev_stage_q;
    logic                done_q, done_d;
    logic                stage_chg, rd_valid, wr_stage_ok, tbl_ok;
    logic [SW-1:0]       rd_stage, wr_sidx;

    always_comb begin
        rd_valid    = 32'(stage_counter) < NUM_STAGES;
        rd_stage    = SW'(stage_counter);
        wr_sidx     = SW'(wr_stage);
        wr_stage_ok = 32'(wr_stage) < NUM_STAGES;
        tbl_ok      = wr_stage_ok && (32'(wr_group) < GROUPS) && (32'(wr_addr) < DEPTH);
        stage_chg   = stage_counter != prev_stage_q;
        // A new stage restarts the sweep: this cycle reads and steps from (0,0,0).
        rd_idx = stage_chg ? '0 : idx_q;
        rd_rep = stage_chg ? '0 : rep_q;
        rd_grp = stage_chg ? '0 : grp_q;
    end

    always_comb begin
        idx_d  = idx_q;
        rep_d  = rep_q;
        grp_d  = grp_q;
        done_d = 1'b0;
        if (!CEN) begin
            rep_d = rd_rep;
            grp_d = rd_grp;
            if (!advance) begin
                idx_d = '0;
            end else if (rd_idx != IW'(DEPTH - 1)) begin
                idx_d = rd_idx + IW'(1);
            end else begin
                idx_d = '0;
                if (rd_rep != RW'(REPEAT - 1)) begin
                    rep_d = rd_rep + RW'(1);
                end else begin
                    rep_d = '0;
                    if (rd_grp != GW'(GROUPS - 1)) begin
                        grp_d = rd_grp + GW'(1);
                    end else begin
                        grp_d  = '0;
                        done_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            rep_q        <= '0;
            grp_q        <= '0;
            done_q       <= 1'b0;
            prev_stage_q <= '0;
            q_q          <= '0;
            qc_q         <= CONST_INIT;
        end else begin
            idx_q        <= idx_d;
            rep_q        <= rep_d;
            grp_q        <= grp_d;
            done_q       <= done_d;
            prev_stage_q <= stage_counter;
            if (!CEN && rd_valid) begin
                q_q  <= mem_q[rd_stage][rd_grp][rd_idx];
                qc_q <= const_q[rd_stage];
            end else begin
                q_q  <= ONE;
            end
        end
    end

    // Nonblocking writes give read-before-write on a same-cycle collision.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                const_q[s] <= CONST_INIT;
                for (int g = 0; g < GROUPS; g++)
                    for (int i = 0; i < DEPTH; i++)
                        mem_q[s][g][i] <= ONE;
            end
        end else begin
            if (wr_en && tbl_ok)
                mem_q[wr_sidx][wr_group][wr_addr] <= wr_data;
            if (cw_en && wr_stage_ok)
                const_q[wr_sidx] <= wr_data;
        end
    end

`ifdef TW_ROM_PARAM_WR_ERR_EN
    logic err_q;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if ((wr_en && !tbl_ok) || (cw_en && !wr_stage_ok) ||
                 (wr_en && !CEN && (wr_stage == stage_counter)))
            err_q <= 1'b1;
    end
    assign wr_err = err_q;
`else
    assign wr_err = 1'b0;
`endif

    assign Q          = q_q;
    assign Q_const    = qc_q;
    assign group_th   = grp_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_tw_rom_param.sv
// Self-checking bench for tw_rom_param: directed steps then random traffic against a
// position-counter model of the sweep.
module tb_tw_rom_param;

    localparam logic [63:0] CINIT = 64'hfff7ffff00000001;
    localparam int NS = 3, DP = 4, GR = 4, RP = 16;
    localparam int TOTAL = DP * RP * GR;

    logic        CLK, rst_n, CEN, advance, wr_en, cw_en;
    logic [2:0]  stage_counter, wr_stage;
    logic [1:0]  wr_group, wr_addr;
    logic [63:0] wr_data, Q, Q_const;
    logic [1:0]  group_th;
    logic        sweep_done, wr_err;

    tw_rom_param dut (
        .CLK(CLK), .rst_n(rst_n), .CEN(CEN), .advance(advance),
        .stage_counter(stage_counter), .wr_en(wr_en), .cw_en(cw_en),
        .wr_stage(wr_stage), .wr_group(wr_group), .wr_addr(wr_addr),
        .wr_data(wr_data), .Q(Q), .Q_const(Q_const), .group_th(group_th),
        .sweep_done(sweep_done), .wr_err(wr_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0, n_pass = 0, n_fail = 0;

    // Model: the sweep is one linear position k in [0, TOTAL).
    logic [63:0] m_mem [NS][GR][DP];
    logic [63:0] m_const [NS];
    int          k, m_prev;
    logic [63:0] m_q, m_qc;
    logic        m_done, m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Q"}, Q, m_q);
        chk({tag, ".Q_const"}, Q_const, m_qc);
        chk({tag, ".group_th"}, 64'(group_th), 64'(k / (DP * RP)));
        chk({tag, ".sweep_done"}, 64'(sweep_done), 64'(m_done));
        chk({tag, ".wr_err"}, 64'(wr_err), 64'(m_err));
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_const[s] = CINIT;
            for (int g = 0; g < GR; g++)
                for (int i = 0; i < DP; i++) m_mem[s][g][i] = 64'd1;
        end
        k = 0; m_prev = 0; m_q = '0; m_qc = CINIT; m_done = 0; m_err = 0;
    endtask

    task automatic cyc(input logic cen, input logic adv, input int st,
                       input logic we, input logic ce, input int ws,
                       input int wg, input int wa, input logic [63:0] wd,
                       input string tag);
        int kb, i, g;
        CEN = cen; advance = adv; stage_counter = 3'(st);
        wr_en = we; cw_en = ce; wr_stage = 3'(ws);
        wr_group = 2'(wg); wr_addr = 2'(wa); wr_data = wd;
        kb = (st != m_prev) ? 0 : k;
        i = kb % DP;
        g = kb / (DP * RP);
        m_done = 0;
        if (!cen) begin
            if (st < NS) begin
                m_q  = m_mem[st][g][i];
                m_qc = m_const[st];
            end else begin
                m_q = 64'd1;
            end
            if (adv) begin
                k = kb + 1;
                if (k == TOTAL) begin k = 0; m_done = 1; end
            end else begin
                k = kb - i;
            end
        end else begin
            m_q = 64'd1;
        end
        m_prev = st;
        if (we && ws < NS) m_mem[ws][wg][wa] = wd;
        if (ce && ws < NS) m_const[ws] = wd;
`ifdef TW_ROM_PARAM_WR_ERR_EN
        if ((we && ws >= NS) || (ce && ws >= NS) || (we && !cen && ws == st)) m_err = 1;
`endif
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic rd(input logic cen, input logic adv, input int st, input string tag);
        cyc(cen, adv, st, 1'b0, 1'b0, 0, 0, 0, 64'd0, tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int st;
        rst_n = 1'b0; CEN = 1'b1; advance = 1'b0; stage_counter = '0;
        wr_en = 1'b0; cw_en = 1'b0; wr_stage = '0; wr_group = '0; wr_addr = '0; wr_data = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        for (int n = 0; n < 4; n++) rd(1'b0, 1'b1, 0, "stage0_identity");

        for (int g = 0; g < GR; g++)
            for (int i = 0; i < DP; i++)
                cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1, g, i, 64'(g * 4 + i), "load_s1");
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b1, 2, 0, 0, 64'h2000, "load_s2_both");

        for (int n = 0; n < TOTAL; n++) rd(1'b0, 1'b1, 1, "sweep_s1");

        for (int n = 0; n < 66; n++) rd(1'b0, 1'b1, 1, "pre_switch");
        rd(1'b0, 1'b1, 2, "stage_switch");
        rd(1'b0, 1'b1, 2, "after_switch");

        cyc(1'b0, 1'b1, 2, 1'b1, 1'b0, 2, 0, 2, 64'hABCD, "rbw_collide");
        for (int n = 0; n < 4; n++) rd(1'b0, 1'b1, 2, "rbw_next_sweep");
        for (int n = 0; n < 3; n++) rd(1'b1, 1'b1, 2, "cen_high_freeze");
        rd(1'b0, 1'b0, 2, "advance0_clear");
        rd(1'b0, 1'b1, 4, "invalid_stage");

        for (int n = 0; n < 5; n++) rd(1'b0, 1'b1, 1, "pre_reset");
        do_reset("mid_sweep_reset");
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 5, 0, 0, 64'hDEAD, "drop_wr_stage5");
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 3, 0, 0, 64'hBEEF, "drop_cw_stage3");
        for (int n = 0; n < 4; n++) rd(1'b0, 1'b1, 0, "err_sticky");

        st = 1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(39) == 0) st = int'($urandom_range(4));
            cyc(($urandom_range(7) == 0), ($urandom_range(5) != 0), st,
                ($urandom_range(4) == 0), ($urandom_range(8) == 0),
                int'($urandom_range(4)), int'($urandom_range(3)), int'($urandom_range(3)),
                {$urandom, $urandom}, "random");
            if (n == 700) do_reset("random_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tw_rom_param.md
Name: tw_rom_param

Overview:
- Parametrised twiddle-factor buffer for the radix-16 NTT/FFT datapath: NUM_STAGES stages × GROUPS groups × DEPTH words, plus one per-stage constant.
- Reads are sequenced by internal index/repeat/group counters, so the butterfly only drives CEN, advance and stage_counter.
- Every word is writable at run time through a direct-addressed write port.
- Replaces the fixed 3-stage, 4-entry twiddle ROMs ahead of the butterfly multipliers.

Parameters:
P_WIDTH, 64, twiddle word width
SC_WIDTH, 3, stage_counter width
NUM_STAGES, 3, stages with stored tables; stage_counter >= NUM_STAGES reads the ONE value
DEPTH, 4, words per group (>=2)
GROUPS, 4, groups per stage (>=1)
REPEAT, 16, full DEPTH sweeps per group before the group advances (>=1)
CONST_INIT, 64'hfff7ffff00000001, reset value of every per-stage constant
IW/GW, $clog2(DEPTH)/$clog2(GROUPS) (minimum 1), derived index and group widths

Ports:
CLK  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
CEN  in  1  active-low read enable
advance  in  1  with CEN low: 1 steps the index, 0 clears the index
stage_counter  in  SC_WIDTH  current butterfly stage
wr_en  in  1  table word write
cw_en  in  1  constant write
wr_stage  in  SC_WIDTH  write target stage (table and constant)
wr_group  in  GW  write target group
wr_addr  in  IW  write target word
wr_data  in  P_WIDTH  write data (table and constant)
Q  out  P_WIDTH  registered twiddle
Q_const  out  P_WIDTH  registered stage constant
group_th  out  GW  current group counter
sweep_done  out  1  one-cycle pulse at the end of the last repeat of the last group
wr_err  out  1  sticky error flag (optional feature only)

Behaviour:
Interface and reset:
- One clock, CLK. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Q = 0; Q_const = CONST_INIT.
  - Every table word = 1 (the multiplicative identity).
  - Every constant = CONST_INIT.
  - idx = rep = grp = 0; sweep_done = 0; wr_err = 0.
  - prev_stage register = 0.
- Reset asserted mid-sweep aborts the sweep immediately; the sequence restarts from idx=0, grp=0.

Read path:
- Latency 1 cycle: the address presented in cycle n appears on Q after edge n+1.
- CEN low and stage_counter < NUM_STAGES: Q <= mem[stage][grp][idx].
- CEN low and stage_counter >= NUM_STAGES: Q <= 1.
- CEN high: Q <= 1; all counters hold.

Stage change:
- stage_counter != prev_stage marks a stage change. prev_stage updates every cycle.
- In a stage-change cycle the read uses idx=0, grp=0, and the counters load the post-step value of the (0,0,0) state.

Sequencing (CEN low, stage valid or invalid):
- advance=1:
  - idx++.
  - At idx==DEPTH-1: idx=0 and rep++.
  - At rep==REPEAT-1: rep=0 and grp++.
  - At grp==GROUPS-1: grp=0 and sweep_done=1 for one cycle.
- advance=0: idx=0; rep and grp hold.
- sweep_done is 0 in every other cycle.

Write path:
- Writes are accepted regardless of CEN.
- wr_en writes mem[wr_stage][wr_group][wr_addr]; cw_en writes const[wr_stage].
- wr_stage >= NUM_STAGES, or wr_group/wr_addr out of range: the write is dropped.
- Write and read to the same word in the same cycle: Q returns the old data (read-before-write). The new data is visible from the next read.
- wr_en and cw_en together: both writes occur.

Constant path:
- CEN low and stage valid: Q_const <= const[stage_counter]. Otherwise Q_const holds.
- Same-cycle cw_en to that stage: Q_const returns the old value.

Output:
- group_th = grp.

Optional Feature:
- Macro: TW_ROM_PARAM_WR_ERR_EN.
- Defined:
  - wr_err sets on any dropped (out-of-range) write.
  - wr_err also sets on a wr_en that targets the stage being read while CEN is low.
  - That write still completes.
  - wr_err clears only on reset.
- Undefined: wr_err is tied to 0 and no check logic is synthesised.

Test Plan:
- Reset, then CEN=0, advance=1, stage 0 for 4 cycles -> Q = 1,1,1,1; Q_const = 64'hfff7ffff00000001.
- Load stage1 group g word i = {g,i} -> stage 1, advance=1 for 64 cycles -> Q = words 0..3 of group 0 ×16; group_th increments after cycle 64.
- Default params, 256 advancing reads on stage 1 -> sweep_done pulses exactly once, on the 256th read; group_th returns to 0.
- Switch stage_counter from 1 to 2 mid-group (idx=2, grp=1) -> the next read returns mem[2][0][0]; counters restart.
- Same-cycle write of 64'hABCD to the word being read -> Q shows the old value, then 64'hABCD on the next sweep; CEN=1 -> Q=1 and counters frozen.
- With TW_ROM_PARAM_WR_ERR_EN, write with wr_stage=5 -> memory unchanged, wr_err=1 and held until rst_n low.
